if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch pipeline. It owns the PC, issues one request per cycle to the synchronous instruction SRAM, and delivers `{pc, inst}` to the decode stage over `fs_to_ds_bus` using the `valid / allow_in` handshake. It consumes the decode stage's `br_bus` to redirect fetch and to squash the wrong-path instruction. An instruction buffer holds SRAM read data while decode back-pressures.

---
 rtl/if_stage_if.sv | 60 ++++++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
//   Bundle of the fetch stage's pipeline-facing and SRAM-facing signals.
//
//   Handshake (valid/ready): fs_to_ds_valid is the fetch stage's "valid" and
//   ds_allow_in is decode's "ready". A transfer happens on a rising clock
//   edge where both are high. While valid is high and ready is low, the
//   payload on fs_to_ds_bus is held stable. br_bus is an unhandshaked
//   sideband from decode that is re-evaluated every cycle.
//
//   Signals
//     ds_allow_in      decode can accept an instruction this cycle
//     br_bus[32:0]     {br_taken, br_target[31:0]} from decode
//     fs_to_ds_valid   fs_to_ds_bus carries a valid instruction
//     fs_to_ds_bus     {fs_pc[31:0], fs_inst[31:0]}
//     inst_sram_en     instruction SRAM read request
//     inst_sram_we     write enables (always 0)
//     inst_sram_addr   request address (next PC)
//     inst_sram_wdata  write data (always 0)
//     inst_sram_rdata  read data, valid the cycle after an enabled request
//
//   Modports
//     master : the fetch stage
//     slave  : the environment (decode stage + instruction SRAM)
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        ds_allow_in;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allow_in,
        input  br_bus,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output ds_allow_in,
        output br_bus,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of a five-stage LoongArch pipeline. Owns the PC,
//   issues one synchronous instruction-SRAM read per cycle, and hands
//   {pc, inst} to decode. A one-entry buffer holds SRAM read data while
//   decode back-pressures, and a pending-branch register remembers a redirect
//   that arrived while fetch could not advance.
//
//   Ports
//     clk               pipeline clock
//     rst               asynchronous, active-high reset
//     bus               if_stage_if.master (decode handshake + SRAM port)
//     dbg_buf_valid_o   instruction buffer holds data
//     dbg_br_pending_o  a redirect is waiting for fetch to advance
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus,
    output logic          dbg_buf_valid_o,
    output logic          dbg_br_pending_o
);

    // fs_pc resets one word before RESET_PC so that the ordinary sequential
    // path (fs_pc + 4) produces the first fetch address.
    localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        fs_valid_q,          fs_valid_d;
    logic [31:0] fs_pc_q,             fs_pc_d;
    logic [31:0] inst_buf_q,          inst_buf_d;
    logic        buf_valid_q,         buf_valid_d;
    logic        br_pending_q,        br_pending_d;
    logic [31:0] br_pending_target_q, br_pending_target_d;

    // ------------------------------------------------------------------
    // Pre-IF: next PC selection
    // ------------------------------------------------------------------
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_allow_in;
    logic        fs_ready_go;
    logic [31:0] fs_inst;

    assign br_taken  = bus.br_bus[32];
    assign br_target = bus.br_bus[31:0];
    assign seq_pc    = fs_pc_q + 32'd4;   // wraps silently at 2^32

    // Live branch beats a remembered one: decode always holds the newest
    // redirect.
    always_comb begin
        nextpc = seq_pc;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pending_q) begin
            nextpc = br_pending_target_q;
        end
    end

    assign fs_ready_go = 1'b1;
    assign fs_allow_in = !fs_valid_q || (fs_ready_go && bus.ds_allow_in);

    // ------------------------------------------------------------------
    // SRAM request
    // ------------------------------------------------------------------
    assign bus.inst_sram_en    = !rst && fs_allow_in;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_wdata = 32'b0;
    // Pin the address to RESET_PC while in reset, whatever decode drives.
    assign bus.inst_sram_addr  = rst ? RESET_PC : nextpc;

    // ------------------------------------------------------------------
    // IF stage outputs
    // ------------------------------------------------------------------
    // SRAM data is only trustworthy the cycle after a request; once the
    // stage stalls the buffered copy is the authoritative instruction.
    assign fs_inst = buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;

    // The slot behind a taken branch (live or remembered) is wrong-path and
    // is squashed rather than delivered.
    assign bus.fs_to_ds_valid = fs_valid_q && fs_ready_go && !br_taken && !br_pending_q;
    assign bus.fs_to_ds_bus   = {fs_pc_q, fs_inst};

    assign dbg_buf_valid_o  = buf_valid_q;
    assign dbg_br_pending_o = br_pending_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fs_valid_d          = fs_valid_q;
        fs_pc_d             = fs_pc_q;
        inst_buf_d          = inst_buf_q;
        buf_valid_d         = buf_valid_q;
        br_pending_d        = br_pending_q;
        br_pending_target_d = br_pending_target_q;

        if (fs_allow_in) begin
            // Advance: the request for nextpc went out this cycle, so any
            // buffered instruction and any remembered redirect are consumed.
            fs_valid_d   = 1'b1;
            fs_pc_d      = nextpc;
            buf_valid_d  = 1'b0;
            br_pending_d = 1'b0;
        end else begin
            // Stalled with a valid instruction: capture SRAM data exactly
            // once, since the SRAM output may drift after en drops.
            if (fs_valid_q && !bus.ds_allow_in && !buf_valid_q) begin
                inst_buf_d  = bus.inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
            // Decode may retire the branch while fetch is stalled; remember
            // the target so the redirect is issued when fetch advances.
            if (br_taken) begin
                br_pending_d        = 1'b1;
                br_pending_target_d = br_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_valid_q          <= 1'b0;
            fs_pc_q             <= PC_RESET_VAL;
            inst_buf_q          <= 32'b0;
            buf_valid_q         <= 1'b0;
            br_pending_q        <= 1'b0;
            br_pending_target_q <= 32'b0;
        end else begin
            fs_valid_q          <= fs_valid_d;
            fs_pc_q             <= fs_pc_d;
            inst_buf_q          <= inst_buf_d;
            buf_valid_q         <= buf_valid_d;
            br_pending_q        <= br_pending_d;
            br_pending_target_q <= br_pending_target_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Directed bench for if_stage. Inputs change on the falling edge and
//   outputs are sampled 1 ns later; the DUT registers on the rising edge.
//   The SRAM model returns the request address as data, with an override
//   that corrupts the read data to show the instruction buffer is in use.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

    logic clk;
    logic rst;
    logic dbg_buf_valid;
    logic dbg_br_pending;

    int checks;
    int errors;

    if_stage_if ifc ();

    if_stage #(.RESET_PC(32'h1C00_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (ifc.master),
        .dbg_buf_valid_o  (dbg_buf_valid),
        .dbg_br_pending_o (dbg_br_pending)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Synchronous SRAM model: data = address of the enabled request
    // ------------------------------------------------------------------
    logic [31:0] sram_q;
    logic        sram_corrupt;

    always @(posedge clk) begin
        if (ifc.inst_sram_en) sram_q <= ifc.inst_sram_addr;
    end
    assign ifc.inst_sram_rdata = sram_corrupt ? 32'hDEAD_BEEF : sram_q;

    // ------------------------------------------------------------------
    // Driver: move to the next cycle and apply inputs
    // ------------------------------------------------------------------
    task automatic drive(input logic allow, input logic taken, input logic [31:0] target);
        @(negedge clk);
        ifc.ds_allow_in = allow;
        ifc.br_bus      = {taken, target};
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        ifc.ds_allow_in = 1'b1;
        ifc.br_bus      = 33'b0;
        sram_corrupt    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ifc.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifc.fs_to_ds_valid); end
        checks++; if (ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", ifc.inst_sram_en); end
        checks++; if (ifc.inst_sram_addr !== 32'h1C00_0000) begin errors++; $display("FAIL rst_addr got %h exp 1c000000", ifc.inst_sram_addr); end
        checks++; if (ifc.fs_to_ds_bus[63:32] !== 32'h1BFF_FFFC) begin errors++; $display("FAIL rst_pc got %h exp 1bfffffc", ifc.fs_to_ds_bus[63:32]); end
        checks++; if (ifc.inst_sram_we !== 4'b0 || ifc.inst_sram_wdata !== 32'b0) begin errors++; $display("FAIL rst_we_wdata got %h/%h exp 0/0", ifc.inst_sram_we, ifc.inst_sram_wdata); end
    endtask

    task automatic test_sequential;
        // C0: release reset
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1C00_0000) begin errors++; $display("FAIL c0_req got en=%b addr=%h exp en=1 addr=1c000000", ifc.inst_sram_en, ifc.inst_sram_addr); end
        checks++; if (ifc.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL c0_valid got %b exp 0", ifc.fs_to_ds_valid); end
        // C1
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0000, 32'h1C00_0000}) begin errors++; $display("FAIL c1_bus got v=%b bus=%h exp v=1 bus=1c0000001c000000", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
        checks++; if (ifc.inst_sram_addr !== 32'h1C00_0004) begin errors++; $display("FAIL c1_addr got %h exp 1c000004", ifc.inst_sram_addr); end
        // C2
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.inst_sram_addr !== 32'h1C00_0008) begin errors++; $display("FAIL c2_addr got %h exp 1c000008", ifc.inst_sram_addr); end
        checks++; if (ifc.fs_to_ds_bus !== {32'h1C00_0004, 32'h1C00_0004}) begin errors++; $display("FAIL c2_bus got %h exp 1c0000041c000004", ifc.fs_to_ds_bus); end
    endtask

    task automatic test_backpressure;
        // Stall cycle 1: fs_pc = 1C000008
        drive(1'b0, 1'b0, 32'h0);
        checks++; if (ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL bp1_en got %b exp 0", ifc.inst_sram_en); end
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0008, 32'h1C00_0008}) begin errors++; $display("FAIL bp1_bus got v=%b bus=%h exp v=1 bus=1c0000081c000008", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
        // Stall cycles 2 and 3 with corrupted SRAM output
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            sram_corrupt = 1'b1;
            #1;
            checks++; if (ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL bp_hold_en[%0d] got %b exp 0", i, ifc.inst_sram_en); end
            checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0008, 32'h1C00_0008}) begin errors++; $display("FAIL bp_hold_bus[%0d] got v=%b bus=%h exp v=1 bus=1c0000081c000008", i, ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
            checks++; if (dbg_buf_valid !== 1'b1) begin errors++; $display("FAIL bp_buf_valid[%0d] got %b exp 1", i, dbg_buf_valid); end
        end
        // Release
        drive(1'b1, 1'b0, 32'h0);
        sram_corrupt = 1'b0;
        #1;
        checks++; if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1C00_000C) begin errors++; $display("FAIL bp_rel_req got en=%b addr=%h exp en=1 addr=1c00000c", ifc.inst_sram_en, ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_bus !== {32'h1C00_000C, 32'h1C00_000C} || ifc.fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL bp_after_bus got v=%b bus=%h exp v=1 bus=1c00000c1c00000c", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
    endtask

    task automatic test_branch;
        // fs_pc = 1C000010 this cycle
        drive(1'b1, 1'b1, 32'h1C00_0100);
        checks++; if (ifc.fs_to_ds_bus[63:32] !== 32'h1C00_0010) begin errors++; $display("FAIL br_pc got %h exp 1c000010", ifc.fs_to_ds_bus[63:32]); end
        checks++; if (ifc.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL br_squash got %b exp 0", ifc.fs_to_ds_valid); end
        checks++; if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1C00_0100) begin errors++; $display("FAIL br_addr got en=%b addr=%h exp en=1 addr=1c000100", ifc.inst_sram_en, ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0100, 32'h1C00_0100}) begin errors++; $display("FAIL br_target_bus got v=%b bus=%h exp v=1 bus=1c0001001c000100", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
        checks++; if (ifc.inst_sram_addr !== 32'h1C00_0104) begin errors++; $display("FAIL br_seq_addr got %h exp 1c000104", ifc.inst_sram_addr); end
    endtask

    task automatic test_branch_stall;
        // fs_pc = 1C000104; decode stalls and raises a branch for one cycle
        drive(1'b0, 1'b1, 32'h1C00_0200);
        checks++; if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL bs0 got v=%b en=%b exp v=0 en=0", ifc.fs_to_ds_valid, ifc.inst_sram_en); end
        drive(1'b0, 1'b0, 32'h0);
        checks++; if (dbg_br_pending !== 1'b1) begin errors++; $display("FAIL bs_pending got %b exp 1", dbg_br_pending); end
        checks++; if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL bs1 got v=%b en=%b exp v=0 en=0", ifc.fs_to_ds_valid, ifc.inst_sram_en); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL bs2_valid got %b exp 0", ifc.fs_to_ds_valid); end
        checks++; if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1C00_0200) begin errors++; $display("FAIL bs2_req got en=%b addr=%h exp en=1 addr=1c000200", ifc.inst_sram_en, ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0200, 32'h1C00_0200}) begin errors++; $display("FAIL bs3_bus got v=%b bus=%h exp v=1 bus=1c0002001c000200", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
        checks++; if (dbg_br_pending !== 1'b0) begin errors++; $display("FAIL bs3_pending got %b exp 0", dbg_br_pending); end
    endtask

    task automatic test_pc_wrap;
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        checks++; if (ifc.inst_sram_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_br_addr got %h exp fffffffc", ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_bus got v=%b bus=%h exp v=1 bus=fffffffcfffffffc", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
        checks++; if (ifc.inst_sram_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_bus !== 64'h0 || ifc.inst_sram_addr !== 32'h0000_0004) begin errors++; $display("FAIL wrap_next got bus=%h addr=%h exp bus=0 addr=00000004", ifc.fs_to_ds_bus, ifc.inst_sram_addr); end
    endtask

    task automatic test_reset_mid;
        // Build up a buffered instruction and a pending branch
        drive(1'b0, 1'b1, 32'h1C00_0300);
        drive(1'b0, 1'b0, 32'h0);
        checks++; if (dbg_buf_valid !== 1'b1 || dbg_br_pending !== 1'b1) begin errors++; $display("FAIL rm_setup got buf=%b pend=%b exp 1/1", dbg_buf_valid, dbg_br_pending); end
        // Assert reset between clock edges
        #1;
        rst = 1'b1;
        #1;
        checks++; if (ifc.fs_to_ds_valid !== 1'b0 || ifc.inst_sram_en !== 1'b0) begin errors++; $display("FAIL rm_async got v=%b en=%b exp 0/0", ifc.fs_to_ds_valid, ifc.inst_sram_en); end
        checks++; if (dbg_buf_valid !== 1'b0 || dbg_br_pending !== 1'b0) begin errors++; $display("FAIL rm_state got buf=%b pend=%b exp 0/0", dbg_buf_valid, dbg_br_pending); end
        checks++; if (ifc.inst_sram_addr !== 32'h1C00_0000 || ifc.fs_to_ds_bus[63:32] !== 32'h1BFF_FFFC) begin errors++; $display("FAIL rm_addr_pc got addr=%h pc=%h exp 1c000000/1bfffffc", ifc.inst_sram_addr, ifc.fs_to_ds_bus[63:32]); end
        // Release and restart
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifc.inst_sram_en !== 1'b1 || ifc.inst_sram_addr !== 32'h1C00_0000) begin errors++; $display("FAIL rm_restart got en=%b addr=%h exp en=1 addr=1c000000", ifc.inst_sram_en, ifc.inst_sram_addr); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (ifc.fs_to_ds_valid !== 1'b1 || ifc.fs_to_ds_bus !== {32'h1C00_0000, 32'h1C00_0000}) begin errors++; $display("FAIL rm_first_bus got v=%b bus=%h exp v=1 bus=1c0000001c000000", ifc.fs_to_ds_valid, ifc.fs_to_ds_bus); end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_branch_stall();
        test_pc_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
